// File: rtl/iob_run_expander_pkg.sv
// Shared types and sizing helpers for the run-length expander.
package iob_run_expander_pkg;

  // Control states of the expander
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Default word width and the matching fill pointer width (must hold 0..N)
  localparam int DEFAULT_N = 21;
  localparam int FILL_W    = $clog2(DEFAULT_N) + 1;

  // Fill pointer width for an arbitrary word width
  function automatic int fill_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/iob_run_mask.sv
// Combinational bit-range mask: ones in [fill, fill+chunk), zeros elsewhere.
// fill + chunk never exceeds N, so no set bits fall off the top.
module iob_run_mask
  import iob_run_expander_pkg::*;
#(
  parameter int N  = 21,
  parameter int FW = fill_width(N)
) (
  input  logic [FW-1:0] fill,
  input  logic [FW-1:0] chunk,
  output logic [N-1:0]  mask
);

  // chunk low ones, shifted up to the fill position
  assign mask = (~({N{1'b1}} << chunk)) << fill;

endmodule

// File: rtl/iob_run_expander.sv
// Run-length expander: turns {symbol, length} runs into N-bit words packed
// LSB-first, with an explicit flush to emit a padded partial word.
// Optional feature macro: IOB_RUN_EXPANDER_CNT_EN adds word_cnt_o, the
// number of non-pad bits in word_o.
module iob_run_expander
  import iob_run_expander_pkg::*;
#(
  parameter int   N     = 21,
  parameter int   LEN_W = 8,
  parameter logic PAD   = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             run_valid_i,
  output logic             run_ready_o,
  input  logic             run_symbol_i,
  input  logic [LEN_W-1:0] run_len_i,
  input  logic             flush_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
`ifdef IOB_RUN_EXPANDER_CNT_EN
  output logic [$clog2(N):0] word_cnt_o,
`endif
  output logic [N-1:0]     word_o
);

  localparam int            FW   = fill_width(N);
  localparam int            CW   = (LEN_W > FW) ? LEN_W : FW;
  localparam logic [FW-1:0] FULL = FW'(N);

  state_t           state_q;
  logic [N-1:0]     asm_q;
  logic [FW-1:0]    fill_q;
  logic [LEN_W-1:0] rem_q;
  logic             sym_q;
  logic             flush_q;
  logic [N-1:0]     word_q;
  logic             word_valid_q;
`ifdef IOB_RUN_EXPANDER_CNT_EN
  logic [FW-1:0]    cnt_q;
`endif

  logic             full;
  logic             out_free;
  logic             flush_xfer;
  logic             do_xfer;
  logic             do_chunk;
  logic [FW-1:0]    eff_fill;
  logic [FW-1:0]    room;
  logic [CW-1:0]    rem_x;
  logic [CW-1:0]    room_x;
  logic [FW-1:0]    chunk;
  logic [FW-1:0]    fill_next;
  logic [LEN_W-1:0] rem_next;
  logic [N-1:0]     asm_base;
  logic [N-1:0]     asm_next;
  logic [N-1:0]     xfer_word;
  logic [N-1:0]     chunk_mask;
  logic [N-1:0]     valid_mask;

  // New runs only while the assembly has room and no flush is waiting
  assign run_ready_o  = (state_q == ST_IDLE) && (fill_q != FULL) && !flush_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
`ifdef IOB_RUN_EXPANDER_CNT_EN
  assign word_cnt_o   = cnt_q;
`endif

  // Bits to set for the current chunk
  iob_run_mask #(.N(N), .FW(FW)) u_chunk_mask (
    .fill  (eff_fill),
    .chunk (chunk),
    .mask  (chunk_mask)
  );

  // Bits of the assembly that hold real data (the rest become PAD)
  iob_run_mask #(.N(N), .FW(FW)) u_valid_mask (
    .fill  ({FW{1'b0}}),
    .chunk (fill_q),
    .mask  (valid_mask)
  );

  // Transfer decision and chunk arithmetic; a transfer frees the assembly in
  // the same cycle so a long run keeps writing and yields one word per cycle
  always_comb begin
    full       = (fill_q == FULL);
    out_free   = !word_valid_q || word_ready_i;
    flush_xfer = (state_q == ST_FLUSH) && (fill_q != '0);
    do_xfer    = out_free && (full || flush_xfer);
    eff_fill   = do_xfer ? '0 : fill_q;
    room       = FULL - eff_fill;
    rem_x      = CW'(rem_q);
    room_x     = CW'(room);
    chunk      = (rem_x < room_x) ? FW'(rem_x) : room;
    do_chunk   = (state_q == ST_FILL) && (eff_fill != FULL);
    asm_base   = do_xfer ? '0 : asm_q;
    asm_next   = (do_chunk && sym_q) ? (asm_base | chunk_mask) : asm_base;
    fill_next  = do_chunk ? (eff_fill + chunk) : eff_fill;
    rem_next   = rem_q - LEN_W'(chunk);
    xfer_word  = PAD ? (asm_q | ~valid_mask) : (asm_q & valid_mask);
  end

  // Control FSM, assembly register and registered output word
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= ST_IDLE;
      asm_q        <= '0;
      fill_q       <= '0;
      rem_q        <= '0;
      sym_q        <= 1'b0;
      flush_q      <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
`ifdef IOB_RUN_EXPANDER_CNT_EN
      cnt_q        <= '0;
`endif
    end else if (cke_i) begin
      asm_q  <= asm_next;
      fill_q <= fill_next;
      if (flush_i) begin
        flush_q <= 1'b1;
      end
      if (do_xfer) begin
        word_q       <= xfer_word;
        word_valid_q <= 1'b1;
`ifdef IOB_RUN_EXPANDER_CNT_EN
        cnt_q        <= fill_q;
`endif
      end else if (word_ready_i) begin
        word_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (run_valid_i && run_ready_o) begin
            sym_q <= run_symbol_i;
            rem_q <= run_len_i;
            if (run_len_i != '0) begin
              state_q <= ST_FILL;
            end
          end else if (flush_q && (rem_q == '0)) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FILL: begin
          if (do_chunk) begin
            rem_q <= rem_next;
            if (rem_next == '0) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if ((fill_q == '0) || do_xfer) begin
            state_q <= ST_IDLE;
            flush_q <= flush_i;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_run_expander.sv
// Testbench for iob_run_expander (N=8). Builds with or without the
// IOB_RUN_EXPANDER_CNT_EN macro; word count checks follow the macro.
module tb_iob_run_expander;

  localparam int   N     = 8;
  localparam int   LEN_W = 8;
  localparam logic PAD   = 1'b0;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             cke = 1'b1;
  logic             run_valid = 1'b0;
  logic             run_ready;
  logic             run_symbol = 1'b0;
  logic [LEN_W-1:0] run_len = '0;
  logic             flush = 1'b0;
  logic             word_valid;
  logic             word_ready = 1'b1;
  logic [N-1:0]     word;
`ifdef IOB_RUN_EXPANDER_CNT_EN
  logic [$clog2(N):0] word_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: bit stream assembled into words, plus delivered-word log
  logic [N-1:0] exp_q[$];
  int           exp_cnt_q[$];
  logic [N-1:0] acc = '0;
  int           acc_n = 0;
  logic [N-1:0] log_q[$];
  int           log_cnt_q[$];

  iob_run_expander #(.N(N), .LEN_W(LEN_W), .PAD(PAD)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .cke_i        (cke),
    .run_valid_i  (run_valid),
    .run_ready_o  (run_ready),
    .run_symbol_i (run_symbol),
    .run_len_i    (run_len),
    .flush_i      (flush),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
`ifdef IOB_RUN_EXPANDER_CNT_EN
    .word_cnt_o   (word_cnt),
`endif
    .word_o       (word)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_bit(input logic b);
    acc[acc_n] = b;
    acc_n++;
    if (acc_n == N) begin
      exp_q.push_back(acc);
      exp_cnt_q.push_back(N);
      acc   = '0;
      acc_n = 0;
    end
  endfunction

  function automatic void model_run(input logic sym, input int len);
    for (int i = 0; i < len; i++) model_bit(sym);
  endfunction

  function automatic void model_flush();
    logic [N-1:0] w;
    if (acc_n > 0) begin
      w = acc;
      for (int i = acc_n; i < N; i++) w[i] = PAD;
      exp_q.push_back(w);
      exp_cnt_q.push_back(acc_n);
      acc   = '0;
      acc_n = 0;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    exp_cnt_q.delete();
    acc   = '0;
    acc_n = 0;
  endfunction

  function automatic logic [N-1:0] log_at(input int i);
    if (log_q.size() > i) return log_q[i];
    return 'x;
  endfunction

  function automatic int log_cnt_at(input int i);
    if (log_cnt_q.size() > i) return log_cnt_q[i];
    return -1;
  endfunction

  // Compare process: check the presented word against the model every cycle,
  // then account for handshakes that take effect at the coming edge
  always @(negedge clk) begin
    if (!arst_n) begin
      model_clear();
    end else begin
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_word_valid", 32'(word_valid), 32'd0);
        end else begin
          check_output("word_o", 32'(word), 32'(exp_q[0]));
`ifdef IOB_RUN_EXPANDER_CNT_EN
          check_output("word_cnt_o", 32'(word_cnt), 32'(exp_cnt_q[0]));
`endif
        end
      end
      if (cke) begin
        if (word_valid && word_ready) begin
          log_q.push_back(word);
          if (exp_q.size() > 0) begin
            log_cnt_q.push_back(exp_cnt_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cnt_q.pop_front());
          end
        end
        if (run_valid && run_ready) model_run(run_symbol, int'(run_len));
        if (flush) model_flush();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Offer one run and hold it until accepted (bounded)
  task automatic apply_stimulus(input logic sym, input int len);
    bit done;
    done       = 1'b0;
    run_valid  = 1'b1;
    run_symbol = sym;
    run_len    = LEN_W'(len);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (run_ready && cke) done = 1'b1;
      @(posedge clk);
      #1;
    end
    run_valid = 1'b0;
    if (!done) check_output("run_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Count edges until word_valid is seen; returns at the sampling negedge
  task automatic wait_valid(output int edges);
    bit found;
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (word_valid) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    if (!found) check_output("word_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cnt_q.delete();
  endtask

  // Watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a randomized phase
  initial begin
    int e;
    logic [LEN_W-1:0] len;

    // Reset state
    #12;
    check_output("reset_word_valid", 32'(word_valid), 32'd0);
    check_output("reset_word_o", 32'(word), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    check_output("reset_run_ready", 32'(run_ready), 32'd1);
    idle(2);

    // Three runs make one word; latency two edges after last handshake
    clear_log();
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 3);
    wait_valid(e);
    check_output("t1_latency", 32'(e), 32'd2);
    idle(4);
    check_output("t1_count", 32'(log_q.size()), 32'd1);
    check_output("t1_word0", 32'(log_at(0)), 32'h0000_00E7);

    // Long run with flush: two full words and a padded partial
    clear_log();
    apply_stimulus(1'b1, 20);
    pulse_flush();
    idle(12);
    check_output("t2_count", 32'(log_q.size()), 32'd3);
    check_output("t2_word0", 32'(log_at(0)), 32'h0000_00FF);
    check_output("t2_word1", 32'(log_at(1)), 32'h0000_00FF);
    check_output("t2_word2", 32'(log_at(2)), 32'h0000_000F);
`ifdef IOB_RUN_EXPANDER_CNT_EN
    check_output("t2_cnt0", 32'(log_cnt_at(0)), 32'd8);
    check_output("t2_cnt1", 32'(log_cnt_at(1)), 32'd8);
    check_output("t2_cnt2", 32'(log_cnt_at(2)), 32'd4);
`endif

    // Blocked output: first word held, input stalled, nothing lost
    clear_log();
    word_ready = 1'b0;
    apply_stimulus(1'b0, 16);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("t3_hold_valid", 32'(word_valid), 32'd1);
      check_output("t3_hold_word", 32'(word), 32'd0);
      check_output("t3_run_ready_low", 32'(run_ready), 32'd0);
      tick();
    end
    word_ready = 1'b1;
    apply_stimulus(1'b1, 8);
    idle(8);
    check_output("t3_count", 32'(log_q.size()), 32'd3);
    check_output("t3_word0", 32'(log_at(0)), 32'h0000_0000);
    check_output("t3_word1", 32'(log_at(1)), 32'h0000_0000);
    check_output("t3_word2", 32'(log_at(2)), 32'h0000_00FF);

    // Zero-length run and empty flush produce nothing
    clear_log();
    apply_stimulus(1'b1, 0);
    @(negedge clk);
    check_output("t4_run_ready", 32'(run_ready), 32'd1);
    tick();
    idle(2);
    pulse_flush();
    idle(6);
    check_output("t4_count", 32'(log_q.size()), 32'd0);
    check_output("t4_word_valid", 32'(word_valid), 32'd0);

    // Asynchronous reset in the middle of a run
    apply_stimulus(1'b1, 20);
    wait_valid(e);
    #2;
    arst_n = 1'b0;
    #1;
    check_output("t5_rst_valid", 32'(word_valid), 32'd0);
    check_output("t5_rst_word", 32'(word), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    arst_n = 1'b1;
    check_output("t5_run_ready", 32'(run_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 8);
    idle(6);
    check_output("t5_count", 32'(log_q.size()), 32'd1);
    check_output("t5_word0", 32'(log_at(0)), 32'h0000_0000);

    // Clock enable low during fill freezes progress
    clear_log();
    apply_stimulus(1'b1, 20);
    cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t6_frozen_valid", 32'(word_valid), 32'd0);
      check_output("t6_frozen_ready", 32'(run_ready), 32'd0);
      tick();
    end
    cke = 1'b1;
    wait_valid(e);
    check_output("t6_resume_latency", 32'(e), 32'd2);
    @(posedge clk);
    #1;
    cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t6_hold_valid", 32'(word_valid), 32'd1);
      check_output("t6_hold_word", 32'(word), 32'h0000_00FF);
      tick();
    end
    cke = 1'b1;
    pulse_flush();
    idle(10);
    check_output("t6_count", 32'(log_q.size()), 32'd3);
    check_output("t6_word0", 32'(log_at(0)), 32'h0000_00FF);
    check_output("t6_word1", 32'(log_at(1)), 32'h0000_00FF);
    check_output("t6_word2", 32'(log_at(2)), 32'h0000_000F);

    // Randomized traffic against the model
    clear_log();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit accepted;
      @(negedge clk);
      accepted = run_valid && run_ready && cke;
      @(posedge clk);
      #1;
      if (!run_valid || accepted) begin
        case ($urandom_range(0, 3))
          0:       len = LEN_W'($urandom_range(0, 3));
          1, 2:    len = LEN_W'($urandom_range(0, 2 * N));
          default: len = LEN_W'($urandom_range(0, 255));
        endcase
        run_valid  = ($urandom_range(0, 3) != 0);
        run_symbol = 1'($urandom);
        run_len    = len;
      end
      flush      = ($urandom_range(0, 15) == 0);
      word_ready = ($urandom_range(0, 3) != 0);
      cke        = ($urandom_range(0, 9) != 0);
    end
    run_valid  = 1'b0;
    flush      = 1'b0;
    cke        = 1'b1;
    word_ready = 1'b1;
    idle(1);
    pulse_flush();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      tick();
    end
    idle(4);
    check_output("drain_pending_words", 32'(exp_q.size()), 32'd0);
    check_output("drain_word_valid", 32'(word_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
